// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch sequencer and its watchdog.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    DISCARD = 3'd2,
    HOLD    = 3'd3,
    ERR     = 3'd4
  } fetch_state_t;

  localparam int unsigned FETCH_DATA_WIDTH = 32;
  localparam int unsigned FETCH_MAX_WAIT   = 15;

endpackage

// File: rtl/fetch_wdog.sv
// Per-request wait counter; flags when the next not-ready cycle reaches MAX_WAIT.
module fetch_wdog
  import fetch_pkg::*;
#(
  parameter int unsigned MAX_WAIT = FETCH_MAX_WAIT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic expiring_o
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear wins over increment; saturate at MAX_WAIT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CW'(MAX_WAIT))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expiring_o = (cnt_q == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer between the hazard unit, PC register and a multi-cycle
// instruction memory: request handshake, stall buffering, redirect discard, timeout.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FETCH_DATA_WIDTH,
  parameter int unsigned MAX_WAIT   = FETCH_MAX_WAIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  StallF,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCF,
  input  logic                  imem_ready,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  output logic                  PCEnF,
  output logic [DATA_WIDTH-1:0] instrF,
  output logic                  InstrValidF,
  output logic                  FlushD,
  output logic                  fetch_err
);

  fetch_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, instr_q;
  logic                  addr_ld, instr_ld;
  logic                  wd_clr, wd_inc, wd_expiring;

  fetch_wdog #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wdog (
    .clk_i      (clk),
    .rst_ni     (reset),
    .clr_i      (wd_clr),
    .inc_i      (wd_inc),
    .expiring_o (wd_expiring)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Transitions; timeout beats a same-cycle redirect.
  always_comb begin
    state_d  = state_q;
    wd_clr   = 1'b0;
    wd_inc   = 1'b0;
    addr_ld  = 1'b0;
    instr_ld = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        wd_clr  = 1'b1;
      end
      REQ: begin
        if (!imem_ready) begin
          wd_inc = 1'b1;
          if (wd_expiring) begin
            state_d = ERR;
          end else if (PCSrcE) begin
            state_d = DISCARD;
            addr_ld = 1'b1;
            wd_clr  = 1'b1;
          end
        end else begin
          wd_clr = 1'b1;
          if (!PCSrcE && StallF) begin
            state_d  = HOLD;
            instr_ld = 1'b1;
          end
        end
      end
      DISCARD: begin
        if (imem_ready) begin
          state_d = REQ;
          wd_clr  = 1'b1;
        end else begin
          wd_inc = 1'b1;
          if (wd_expiring) begin
            state_d = ERR;
          end
        end
      end
      HOLD: begin
        if (PCSrcE || !StallF) begin
          state_d = REQ;
          wd_clr  = 1'b1;
        end
      end
      ERR: state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  // Mealy outputs; the request address follows PCF because PCF only moves with PCEnF.
  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = '0;
    PCEnF       = 1'b0;
    instrF      = instr_q;
    InstrValidF = 1'b0;
    FlushD      = 1'b0;
    fetch_err   = 1'b0;
    case (state_q)
      IDLE: begin
        FlushD = PCSrcE & reset;
        PCEnF  = PCSrcE & reset;
      end
      REQ: begin
        imem_req  = 1'b1;
        imem_addr = PCF;
        FlushD    = PCSrcE;
        if (PCSrcE) begin
          PCEnF = 1'b1;
        end else if (imem_ready) begin
          instrF      = imem_rdata;
          InstrValidF = 1'b1;
          PCEnF       = !StallF;
        end
      end
      DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = addr_q;
        FlushD    = PCSrcE;
        PCEnF     = PCSrcE;
      end
      HOLD: begin
        FlushD      = PCSrcE;
        InstrValidF = !PCSrcE;
        PCEnF       = PCSrcE | !StallF;
      end
      ERR: fetch_err = 1'b1;
      default: ;
    endcase
  end

  // Address of an abandoned request, and the instruction parked during a stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      instr_q <= '0;
    end else begin
      if (addr_ld) begin
        addr_q <= PCF;
      end
      if (instr_ld) begin
        instr_q <= imem_rdata;
      end
    end
  end

endmodule
